// File: rtl/itcm_ctrl_pkg.sv
// Shared ITCM defines, constants and response type.
// Macro ITCM_ACC_CHK_EN (consumed by itcm_ctrl) enables fetch access checking.
`ifndef ITCM_DEFINES_SVH
`define ITCM_DEFINES_SVH
`define PC_SIZE 32
`define INSTR_SIZE 32
`define ITCM_NOP 32'h0000_0013
`endif

package itcm_ctrl_pkg;

  localparam int RSP_W = `INSTR_SIZE + 1;
  localparam logic [`INSTR_SIZE-1:0] ITCM_NOP = `ITCM_NOP;

  typedef struct packed {
    logic                    err;
    logic [`INSTR_SIZE-1:0]  instr;
  } itcm_rsp_t;

endpackage

// File: rtl/itcm_rsp_fifo.sv
// Two-entry response FIFO holding {err, instr}; pointers and count are reset,
// the storage array is not.
module itcm_rsp_fifo
  import itcm_ctrl_pkg::*;
#(
  parameter int W = RSP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   cnt,
  output logic [W-1:0] head
);

  logic [W-1:0] r_mem [0:1];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (push) r_wptr <= ~r_wptr;
      if (pop)  r_rptr <= ~r_rptr;
      unique case ({push, pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= push_data;
  end

  assign cnt  = r_cnt;
  assign head = r_mem[r_rptr];

endmodule

// File: rtl/itcm_ctrl.sv
// Instruction TCM fetch controller: single-cycle SRAM read with bypass and a
// 2-entry response FIFO. Define ITCM_ACC_CHK_EN to fault misaligned/out-of-range fetches.
module itcm_ctrl
  import itcm_ctrl_pkg::*;
#(
  parameter int                    RAM_AW    = 14,
  parameter logic [`PC_SIZE-1:0]   ITCM_BASE = 32'h8000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [`PC_SIZE-1:0]     ifu_req_pc,
  output logic                    ifu_rsp_valid,
  input  logic                    ifu_rsp_ready,
  output logic [`INSTR_SIZE-1:0]  ifu_rsp_instr,
  output logic                    ifu_rsp_err,
  output logic                    ram_cs,
  output logic [RAM_AW-1:0]       ram_addr,
  input  logic [31:0]             ram_rdata
);

  logic                  r_inflight;
  logic [1:0]            w_cnt;
  logic                  w_fire;
  logic                  w_bad;
  logic                  w_push;
  logic                  w_pop;
  logic [`PC_SIZE-1:0]   w_off;
  itcm_rsp_t             w_head;
  itcm_rsp_t             w_bypass;
  itcm_rsp_t             w_rsp;
  logic                  w_unused;

  assign w_off    = ifu_req_pc - ITCM_BASE;
  assign ram_addr = w_off[RAM_AW+1:2];

  // At most two responses outstanding: one read in flight plus FIFO entries.
  assign ifu_req_ready = !rst && (({1'b0, r_inflight} + w_cnt) < 2'd2);
  assign w_fire        = ifu_req_valid && ifu_req_ready;
  assign ram_cs        = w_fire && !w_bad;

`ifdef ITCM_ACC_CHK_EN
  logic r_inflight_err;

  assign w_bad = (ifu_req_pc[1:0] != 2'b00) || (ifu_req_pc < ITCM_BASE) ||
                 ((w_off >> (RAM_AW + 2)) != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_inflight_err <= 1'b0;
    else     r_inflight_err <= w_fire && w_bad;
  end

  assign w_bypass    = r_inflight_err ? itcm_rsp_t'{err: 1'b1, instr: ITCM_NOP}
                                      : itcm_rsp_t'{err: 1'b0, instr: ram_rdata};
  assign ifu_rsp_err = w_rsp.err;
  assign w_unused    = ^w_off[1:0];
`else
  assign w_bad       = 1'b0;
  assign w_bypass    = itcm_rsp_t'{err: 1'b0, instr: ram_rdata};
  assign ifu_rsp_err = 1'b0;
  assign w_unused    = ^{w_off[`PC_SIZE-1:RAM_AW+2], w_off[1:0], w_rsp.err};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_inflight <= 1'b0;
    else     r_inflight <= w_fire;
  end

  // Older FIFO entries always win; fresh read data bypasses only into an empty FIFO.
  assign w_rsp         = (w_cnt == 2'd0) ? w_bypass : w_head;
  assign ifu_rsp_valid = r_inflight || (w_cnt != 2'd0);
  assign ifu_rsp_instr = w_rsp.instr;
  assign w_pop         = (w_cnt != 2'd0) && ifu_rsp_ready;
  assign w_push        = r_inflight && !((w_cnt == 2'd0) && ifu_rsp_ready);

  itcm_rsp_fifo #(.W(RSP_W)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_bypass),
    .pop       (w_pop),
    .cnt       (w_cnt),
    .head      (w_head)
  );

endmodule

// File: tb/tb_itcm_ctrl.sv
// Self-checking bench for itcm_ctrl: credit/queue reference model plus directed
// and random fetch sequences; ITCM_ACC_CHK_EN adds access-fault scenarios.
module tb_itcm_ctrl;

  localparam int          AW   = 14;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu_req_valid = 1'b0;
  logic          ifu_req_ready;
  logic [31:0]   ifu_req_pc = BASE;
  logic          ifu_rsp_valid;
  logic          ifu_rsp_ready = 1'b1;
  logic [31:0]   ifu_rsp_instr;
  logic          ifu_rsp_err;
  logic          ram_cs;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata = 32'h0;

  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  int n_pop = 0;

  typedef struct {
    logic        err;
    logic [31:0] instr;
  } rsp_t;

  rsp_t q[$];

  always #5 clk = ~clk;

  itcm_ctrl #(.RAM_AW(AW), .ITCM_BASE(BASE)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_pc    (ifu_req_pc),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_instr (ifu_rsp_instr),
    .ifu_rsp_err   (ifu_rsp_err),
    .ram_cs        (ram_cs),
    .ram_addr      (ram_addr),
    .ram_rdata     (ram_rdata)
  );

  function automatic logic [31:0] word_of(logic [AW-1:0] a);
    if (a == AW'(2)) return 32'h00A0_0093;
    return ({16'd0, a, 2'b01} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // SRAM: data the cycle after a read; garbage otherwise to expose stale-data use.
  always @(posedge clk) begin
    if (ram_cs) ram_rdata <= word_of(ram_addr);
    else        ram_rdata <= $urandom();
  end

  function automatic rsp_t expect_of(logic [31:0] pc);
    rsp_t        r;
    logic [31:0] off;
    off = pc - BASE;
`ifdef ITCM_ACC_CHK_EN
    if (pc[1:0] != 2'b00 || pc < BASE || off >= (32'd4 << AW)) begin
      r.err   = 1'b1;
      r.instr = NOP;
      return r;
    end
`endif
    r.err   = 1'b0;
    r.instr = word_of(off[AW+1:2]);
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a response queue of accepted fetches; at most two outstanding,
  // each response visible the cycle after its request and held until taken.
  initial begin : model
    logic        acc;
    logic        pop;
    rsp_t        exp_r;
    logic [31:0] off;
    forever begin
      @(negedge clk);
      acc = 1'b0;
      pop = 1'b0;
      if (rst) begin
        q.delete();
        check("rst_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
        check("rst_ram_cs", 32'(ram_cs), 32'd0);
      end else begin
        exp_r = expect_of(ifu_req_pc);
        off   = ifu_req_pc - BASE;
        check("req_ready", 32'(ifu_req_ready), 32'(q.size() < 2));
        check("rsp_valid", 32'(ifu_rsp_valid), 32'(q.size() > 0));
        check("ram_cs", 32'(ram_cs), 32'(ifu_req_valid && q.size() < 2 && !exp_r.err));
        if (ram_cs) check("ram_addr", 32'(ram_addr), 32'(off[AW+1:2]));
        if (q.size() > 0) begin
          check("rsp_instr", ifu_rsp_instr, q[0].instr);
          check("rsp_err", 32'(ifu_rsp_err), 32'(q[0].err));
        end
        acc = ifu_req_valid && ifu_req_ready;
        pop = ifu_rsp_valid && ifu_rsp_ready;
      end
      @(posedge clk);
      if (!rst) begin
        if (pop) begin
          n_pop++;
          $display("[TB] rsp  instr=%h err=%0d t=%0t", ifu_rsp_instr, ifu_rsp_err, $time);
          if (q.size() > 0) void'(q.pop_front());
        end
        if (acc) begin
          n_acc++;
          q.push_back(exp_r);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int a0;
    int c0;
    int cyc;
    int target;
    int r;

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(ifu_req_ready), 32'd1);
    check("post_rst_valid", 32'(ifu_rsp_valid), 32'd0);

    // Single fetch of word 2.
    tick();
    ifu_req_valid = 1'b1;
    ifu_req_pc    = BASE + 32'd8;
    @(negedge clk);
    check("single_cs", 32'(ram_cs), 32'd1);
    check("single_addr", 32'(ram_addr), 32'd2);
    tick();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    check("single_valid", 32'(ifu_rsp_valid), 32'd1);
    check("single_instr", ifu_rsp_instr, 32'h00A0_0093);

    // Eight back-to-back fetches with the consumer always ready.
    tick();
    c0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      ifu_req_valid = 1'b1;
      ifu_req_pc    = BASE + 32'(4 * (i + 16));
      @(negedge clk);
      check("b2b_ready", 32'(ifu_req_ready), 32'd1);
      if (i > 0) check("b2b_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
      tick();
    end
    ifu_req_valid = 1'b0;
    repeat (2) tick();
    check("b2b_count", 32'(n_pop - c0), 32'd8);

    // Backpressure: consumer stalled for 5 cycles under continuous requests.
    ifu_rsp_ready = 1'b0;
    ifu_req_valid = 1'b1;
    a0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      ifu_req_pc = BASE + 32'h100 + 32'(4 * i);
      if (i < 4) tick();
    end
    @(negedge clk);
    check("stall_ready", 32'(ifu_req_ready), 32'd0);
    check("stall_cs", 32'(ram_cs), 32'd0);
    check("stall_accepted", 32'(n_acc - a0), 32'd2);
    tick();
    ifu_rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ifu_req_pc = BASE + 32'h200 + 32'(4 * i);
      tick();
    end
    ifu_req_valid = 1'b0;
    repeat (3) tick();

`ifdef ITCM_ACC_CHK_EN
    // Misaligned fetch faults without touching SRAM; aligned fetch behind it is normal.
    ifu_req_valid = 1'b1;
    ifu_req_pc    = BASE + 32'd2;
    @(negedge clk);
    check("chk_bad_cs", 32'(ram_cs), 32'd0);
    tick();
    ifu_req_pc = BASE;
    @(negedge clk);
    check("chk_good_cs", 32'(ram_cs), 32'd1);
    check("chk_bad_err", 32'(ifu_rsp_err), 32'd1);
    check("chk_bad_instr", ifu_rsp_instr, NOP);
    tick();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    check("chk_good_err", 32'(ifu_rsp_err), 32'd0);
    check("chk_good_instr", ifu_rsp_instr, word_of(AW'(0)));
    tick();
`endif

    // Random traffic with a 50% consumer.
    target = n_acc + 1000;
    cyc    = 0;
    while (n_acc < target && cyc < 20000) begin
      ifu_req_valid = ($urandom_range(0, 3) != 0);
      ifu_rsp_ready = ($urandom_range(0, 1) == 1);
      r = int'($urandom_range(0, 9));
      ifu_req_pc = BASE + (32'($urandom_range(0, (1 << AW) - 1)) << 2);
`ifdef ITCM_ACC_CHK_EN
      if (r == 0) ifu_req_pc = BASE + 32'd6;
      if (r == 1) ifu_req_pc = BASE - 32'd4;
      if (r == 2) ifu_req_pc = BASE + (32'd4 << AW);
`endif
      tick();
      cyc++;
    end
    check("rand_budget", 32'(n_acc >= target), 32'd1);
    ifu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b1;
    repeat (4) tick();
    check("rand_no_loss", 32'(n_pop), 32'(n_acc));
    check("rand_drained", 32'(q.size()), 32'd0);

    // Reset with two responses outstanding discards them.
    ifu_rsp_ready = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_req_pc    = BASE + 32'h40;
    repeat (3) tick();
    rst           = 1'b1;
    ifu_req_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(ifu_rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_ready", 32'(ifu_req_ready), 32'd1);
    check("after_rst_valid", 32'(ifu_rsp_valid), 32'd0);
    tick();
    ifu_rsp_ready = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_req_pc    = BASE + 32'd8;
    tick();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    check("after_rst_rsp", 32'(ifu_rsp_valid), 32'd1);
    check("after_rst_instr", ifu_rsp_instr, 32'h00A0_0093);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
